// File: rtl/wb4_fifo_pkg.sv
// rtl/wb4_fifo_pkg.sv - shared state encoding and sizing helpers for the wb4 width-conversion FIFOs
// Contents:
//   fifo_state_e  read-side FSM encoding (IDLE, FETCH, VALID)
//   ratio_f       wide/narrow width ratio from the two data MSB parameters
//   addr_msb_f    memory pointer MSB for a power-of-two depth
//   lane_w_f      lane counter width for a power-of-two ratio
package wb4_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fifo_state_e;

    function automatic int ratio_f(input int wide_msb, input int narrow_msb);
        return (wide_msb + 1) / (narrow_msb + 1);
    endfunction

    function automatic int addr_msb_f(input int depth);
        return $clog2(depth) - 1;
    endfunction

    function automatic int lane_w_f(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/wb4_sync_fifo_1_to_n_if.sv
// rtl/wb4_sync_fifo_1_to_n_if.sv - write/read Wishbone B4 pipelined slave bundle of the 1-to-N FIFO
// Signals (direction as seen by the FIFO, i.e. the slave modport):
//   i_wb4_in_scyc/sstb/sdata   wide write cycle, strobe, data
//   o_wb4_in_sack/stgd/sstall  write ack, FIFO empty, FIFO full
//   i_wb4_out_scyc/sstb        narrow read cycle, strobe
//   o_wb4_out_sack/sdata       read ack, narrow read data
//   o_wb4_out_stgd/sstall      FIFO full, no narrow word available
// Modports: slave (the FIFO), master (producer/consumer side).
interface wb4_sync_fifo_1_to_n_if #(
    parameter int P_DATA_I_MSB = 31,
    parameter int P_DATA_O_MSB = 7
);
    logic                  i_wb4_in_scyc;
    logic                  i_wb4_in_sstb;
    logic                  o_wb4_in_sack;
    logic [P_DATA_I_MSB:0] i_wb4_in_sdata;
    logic                  o_wb4_in_stgd;
    logic                  o_wb4_in_sstall;
    logic                  i_wb4_out_scyc;
    logic                  i_wb4_out_sstb;
    logic                  o_wb4_out_sack;
    logic [P_DATA_O_MSB:0] o_wb4_out_sdata;
    logic                  o_wb4_out_stgd;
    logic                  o_wb4_out_sstall;

    modport slave (
        input  i_wb4_in_scyc, i_wb4_in_sstb, i_wb4_in_sdata,
        input  i_wb4_out_scyc, i_wb4_out_sstb,
        output o_wb4_in_sack, o_wb4_in_stgd, o_wb4_in_sstall,
        output o_wb4_out_sack, o_wb4_out_sdata, o_wb4_out_stgd, o_wb4_out_sstall
    );

    modport master (
        output i_wb4_in_scyc, i_wb4_in_sstb, i_wb4_in_sdata,
        output i_wb4_out_scyc, i_wb4_out_sstb,
        input  o_wb4_in_sack, o_wb4_in_stgd, o_wb4_in_sstall,
        input  o_wb4_out_sack, o_wb4_out_sdata, o_wb4_out_stgd, o_wb4_out_sstall
    );
endinterface

// File: rtl/wb4_fifo_unpacker.sv
// rtl/wb4_fifo_unpacker.sv - wide holding register, lane counter and narrow lane multiplexer
// Macro: WB4_FIFO_1_TO_N_MSB_FIRST_EN delivers the most significant lane first.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   load_i         capture data_i into the holding register, restart at lane 0
//   clear_i        holding register fully consumed with nothing left to load
//   accept_i       narrow read accepted: register current lane, advance lane
//   data_i         wide word from memory
//   hold_vld_o     holding register has unread lanes
//   lane_last_o    current lane is the final one of the wide word
//   sdata_o        registered narrow read data
module wb4_fifo_unpacker
    import wb4_fifo_pkg::*;
#(
    parameter int P_DATA_I_MSB = 31,
    parameter int P_DATA_O_MSB = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [P_DATA_I_MSB:0] data_i,
    output logic                  hold_vld_o,
    output logic                  lane_last_o,
    output logic [P_DATA_O_MSB:0] sdata_o
);
    localparam int L_RATIO  = ratio_f(P_DATA_I_MSB, P_DATA_O_MSB);
    localparam int L_LANE_W = lane_w_f(L_RATIO);
    localparam int L_O_W    = P_DATA_O_MSB + 1;

    logic [P_DATA_I_MSB:0] r_hold_q;
    logic                  r_hold_vld_q;
    logic [L_LANE_W-1:0]   r_lane_q;
    logic [L_LANE_W-1:0]   lane_sel;
    logic [P_DATA_O_MSB:0] lane_word;
    logic [P_DATA_O_MSB:0] sdata_q;

    always_comb begin
`ifdef WB4_FIFO_1_TO_N_MSB_FIRST_EN
        // L_RATIO is a power of two, so L_RATIO-1-k is simply ~k
        lane_sel = ~r_lane_q;
`else
        lane_sel = r_lane_q;
`endif
        lane_word = r_hold_q[32'(lane_sel) * L_O_W +: L_O_W];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_q     <= '0;
            r_hold_vld_q <= 1'b0;
            r_lane_q     <= '0;
            sdata_q      <= '0;
        end else begin
            if (accept_i) begin
                sdata_q  <= lane_word;
                r_lane_q <= r_lane_q + 1'b1;
            end
            // A load on the last-lane accept refills the register back-to-back
            if (load_i) begin
                r_hold_q     <= data_i;
                r_hold_vld_q <= 1'b1;
                r_lane_q     <= '0;
            end else if (clear_i) begin
                r_hold_vld_q <= 1'b0;
            end
        end
    end

    assign hold_vld_o  = r_hold_vld_q;
    assign lane_last_o = &r_lane_q;
    assign sdata_o     = sdata_q;

endmodule

// File: rtl/wb4_sync_fifo_1_to_n.sv
// rtl/wb4_sync_fifo_1_to_n.sv - single-clock Wishbone B4 FIFO, wide words in, narrow words out
// Macro: WB4_FIFO_1_TO_N_MSB_FIRST_EN reverses lane order (most significant lane first).
// Parameters: P_DATA_I_MSB, P_DATA_O_MSB (ratio a power of two >= 2), P_DEPTH (power of two >= 2),
//             P_USE_BRAM (1 synchronous-read array, 0 LUT array; same cycle behaviour).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   wb_io          write and read Wishbone slave signals (see wb4_sync_fifo_1_to_n_if)
module wb4_sync_fifo_1_to_n
    import wb4_fifo_pkg::*;
#(
    parameter int P_DATA_I_MSB = 31,
    parameter int P_DATA_O_MSB = 7,
    parameter int P_DEPTH      = 16,
    parameter int P_USE_BRAM   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    wb4_sync_fifo_1_to_n_if.slave        wb_io
);
    localparam int L_ADDR_MSB = addr_msb_f(P_DEPTH);
    localparam int L_ADDR_W   = L_ADDR_MSB + 1;
    localparam int L_CNT_W    = L_ADDR_MSB + 2;
    localparam logic [L_CNT_W-1:0] L_FULL = L_CNT_W'(P_DEPTH);

    fifo_state_e           state_q;
    logic [L_ADDR_MSB:0]   wr_ptr_q, wr_ptr_d;
    logic [L_ADDR_MSB:0]   rd_ptr_q, rd_ptr_d;
    logic [L_CNT_W-1:0]    count_q, count_d;
    logic                  in_sack_q, out_sack_q;
    logic                  full, wr_acc, rd_acc;
    logic                  hold_vld, lane_last, hold_load, hold_clr;
    logic [P_DATA_I_MSB:0] mem_dout;
    logic [P_DATA_O_MSB:0] sdata;
    logic [P_DATA_I_MSB:0] mem_q [P_DEPTH];

    always_comb begin
        full      = (count_q == L_FULL);
        wr_acc    = wb_io.i_wb4_in_scyc & wb_io.i_wb4_in_sstb & ~full;
        rd_acc    = wb_io.i_wb4_out_scyc & wb_io.i_wb4_out_sstb & hold_vld;
        // Refill from the memory output on the last lane when words remain
        hold_load = (state_q == ST_FETCH)
                  | ((state_q == ST_VALID) & rd_acc & lane_last & (count_q != '0));
        hold_clr  = (state_q == ST_VALID) & rd_acc & lane_last & (count_q == '0);
        wr_ptr_d  = wr_ptr_q + L_ADDR_W'(wr_acc);
        rd_ptr_d  = rd_ptr_q + L_ADDR_W'(hold_load);
        count_d   = count_q + L_CNT_W'(wr_acc) - L_CNT_W'(hold_load);
    end

    // Both variants present mem[rd_ptr_q] on mem_dout in every cycle
    generate
        if (P_USE_BRAM != 0) begin : g_bram
            logic [P_DATA_I_MSB:0] rd_data_q;
            // Read the next pointer so the registered output lines up with rd_ptr_q;
            // write-first bypass covers a word landing at that address on this edge.
            always_ff @(posedge i_clk) begin
                if (wr_acc) begin
                    mem_q[wr_ptr_q] <= wb_io.i_wb4_in_sdata;
                end
                if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                    rd_data_q <= wb_io.i_wb4_in_sdata;
                end else begin
                    rd_data_q <= mem_q[rd_ptr_d];
                end
            end
            assign mem_dout = rd_data_q;
        end else begin : g_lut
            always_ff @(posedge i_clk) begin
                if (wr_acc) begin
                    mem_q[wr_ptr_q] <= wb_io.i_wb4_in_sdata;
                end
            end
            assign mem_dout = mem_q[rd_ptr_q];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_sack_q  <= 1'b0;
            out_sack_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_sack_q  <= wr_acc;
            out_sack_q <= rd_acc;
            case (state_q)
                ST_IDLE:  if (count_q != '0) state_q <= ST_FETCH;
                ST_FETCH: state_q <= ST_VALID;
                ST_VALID: if (hold_clr) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    wb4_fifo_unpacker #(
        .P_DATA_I_MSB (P_DATA_I_MSB),
        .P_DATA_O_MSB (P_DATA_O_MSB)
    ) u_unpacker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .load_i      (hold_load),
        .clear_i     (hold_clr),
        .accept_i    (rd_acc),
        .data_i      (mem_dout),
        .hold_vld_o  (hold_vld),
        .lane_last_o (lane_last),
        .sdata_o     (sdata)
    );

    assign wb_io.o_wb4_in_sack    = in_sack_q;
    assign wb_io.o_wb4_in_stgd    = (count_q == '0) & ~hold_vld;
    assign wb_io.o_wb4_in_sstall  = full;
    assign wb_io.o_wb4_out_sack   = out_sack_q;
    assign wb_io.o_wb4_out_sdata  = sdata;
    assign wb_io.o_wb4_out_stgd   = full;
    assign wb_io.o_wb4_out_sstall = ~hold_vld;

endmodule

// File: tb/tb_wb4_sync_fifo_1_to_n.sv
// tb/tb_wb4_sync_fifo_1_to_n.sv - randomized self-checking bench for wb4_sync_fifo_1_to_n
`timescale 1ns/1ps
module tb_wb4_sync_fifo_1_to_n;
    localparam int W_I   = 32;
    localparam int W_O   = 8;
    localparam int RATIO = W_I / W_O;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    wb4_sync_fifo_1_to_n_if #(.P_DATA_I_MSB(W_I-1), .P_DATA_O_MSB(W_O-1)) bus ();

    wb4_sync_fifo_1_to_n #(
        .P_DATA_I_MSB (W_I-1),
        .P_DATA_O_MSB (W_O-1),
        .P_DEPTH      (DEPTH),
        .P_USE_BRAM   (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .wb_io (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W_O-1:0] lane_of(input logic [W_I-1:0] w, input int k);
`ifdef WB4_FIFO_1_TO_N_MSB_FIRST_EN
        return w[(RATIO-1-k)*W_O +: W_O];
`else
        return w[k*W_O +: W_O];
`endif
    endfunction

    // Reference model: words waiting in memory, narrow lanes left in the holding
    // register, and one pending flag for the single bubble between noticing a
    // stored word and having it in the holding register.
    logic [W_I-1:0] mq[$];
    logic [W_O-1:0] hq[$];
    bit             pend = 0;
    logic           m_in_sack = 0, m_out_sack = 0;
    logic [W_O-1:0] m_sdata = '0;
    bit             have_prev = 0;
    logic           p_rst, p_icyc, p_istb, p_ocyc, p_ostb;
    logic [W_I-1:0] p_idata;

    function automatic void load_lanes(input logic [W_I-1:0] w);
        for (int k = 0; k < RATIO; k++) hq.push_back(lane_of(w, k));
    endfunction

    function automatic void model_step();
        bit wr, rd;
        int mem_words;
        if (p_rst) begin
            mq.delete(); hq.delete(); pend = 0;
            m_in_sack = 0; m_out_sack = 0; m_sdata = '0;
            return;
        end
        mem_words  = mq.size();
        wr         = p_icyc && p_istb && (mem_words != DEPTH);
        rd         = p_ocyc && p_ostb && (hq.size() != 0);
        m_in_sack  = wr;
        m_out_sack = rd;
        if (rd) begin
            m_sdata = hq.pop_front();
            if (hq.size() == 0 && mem_words != 0) load_lanes(mq.pop_front());
        end else if (hq.size() == 0) begin
            if (pend) begin
                load_lanes(mq.pop_front());
                pend = 0;
            end else if (mem_words != 0) begin
                pend = 1;
            end
        end
        if (wr) mq.push_back(p_idata);
    endfunction

    // Inputs are stable at the falling edge; outputs there reflect the previous rising edge
    always @(negedge clk) begin
        if (have_prev) begin
            model_step();
            check_eq("m_in_sack",    bus.o_wb4_in_sack,    m_in_sack);
            check_eq("m_out_sack",   bus.o_wb4_out_sack,   m_out_sack);
            check_eq("m_out_sdata",  bus.o_wb4_out_sdata,  m_sdata);
            check_eq("m_in_sstall",  bus.o_wb4_in_sstall,  mq.size() == DEPTH);
            check_eq("m_out_stgd",   bus.o_wb4_out_stgd,   mq.size() == DEPTH);
            check_eq("m_out_sstall", bus.o_wb4_out_sstall, hq.size() == 0);
            check_eq("m_in_stgd",    bus.o_wb4_in_stgd,    (mq.size() == 0) && (hq.size() == 0));
        end
        have_prev = 1;
        p_rst   = rst;
        p_icyc  = bus.i_wb4_in_scyc;
        p_istb  = bus.i_wb4_in_sstb;
        p_idata = bus.i_wb4_in_sdata;
        p_ocyc  = bus.i_wb4_out_scyc;
        p_ostb  = bus.i_wb4_out_sstb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic en, input logic [W_I-1:0] d);
        bus.i_wb4_in_scyc  = en;
        bus.i_wb4_in_sstb  = en;
        bus.i_wb4_in_sdata = d;
    endtask

    task automatic drive_rd(input logic en);
        bus.i_wb4_out_scyc = en;
        bus.i_wb4_out_sstb = en;
    endtask

    // Collect narrow acks until 'want' arrive or the cycle budget runs out
    task automatic read_expect(input string tag, input logic [W_I-1:0] words[$], input int want);
        int got = 0;
        int n = 0;
        while (got < want && n < 4 * want + 20) begin
            tick(); n++;
            if (bus.o_wb4_out_sack) begin
                check_eq(tag, bus.o_wb4_out_sdata, lane_of(words[got / RATIO], got % RATIO));
                got++;
            end
        end
        check_eq({tag, "_count"}, got, want);
    endtask

    task automatic stream(input int words, input bit rd_always);
        int sent = 0;
        int n = 0;
        while (sent < words && n < 2000) begin
            logic c, s, acc;
            c = ($urandom_range(7) != 0);
            s = ($urandom_range(3) != 0);
            bus.i_wb4_in_scyc  = c;
            bus.i_wb4_in_sstb  = s;
            bus.i_wb4_in_sdata = $urandom;
            if (rd_always) drive_rd(1'b1);
            else begin
                bus.i_wb4_out_scyc = ($urandom_range(7) != 0);
                bus.i_wb4_out_sstb = ($urandom_range(3) != 0);
            end
            acc = c & s & ~bus.o_wb4_in_sstall;
            tick(); n++;
            if (acc) sent++;
        end
        drive_wr(1'b0, '0);
        check_eq("stream_words", sent, words);
    endtask

    logic [W_I-1:0] wq[$];

    initial begin
        drive_wr(1'b0, '0);
        drive_rd(1'b0);
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_in_stgd",    bus.o_wb4_in_stgd,    1);
        check_eq("rst_out_sstall", bus.o_wb4_out_sstall, 1);
        check_eq("rst_in_sstall",  bus.o_wb4_in_sstall,  0);
        check_eq("rst_out_stgd",   bus.o_wb4_out_stgd,   0);
        check_eq("rst_in_sack",    bus.o_wb4_in_sack,    0);
        check_eq("rst_out_sack",   bus.o_wb4_out_sack,   0);
        check_eq("rst_out_sdata",  bus.o_wb4_out_sdata,  0);
        rst = 1'b0;
        tick();

        // Single word: latency and lane order
        drive_wr(1'b1, 32'h44332211);
        tick();
        drive_wr(1'b0, '0);
        check_eq("sw_in_sack",   bus.o_wb4_in_sack,    1);
        check_eq("sw_stall_t1",  bus.o_wb4_out_sstall, 1);
        drive_rd(1'b1);
        tick();
        check_eq("sw_stall_t2",  bus.o_wb4_out_sstall, 1);
        tick();
        check_eq("sw_stall_t3",  bus.o_wb4_out_sstall, 0);
        check_eq("sw_ack_t3",    bus.o_wb4_out_sack,   0);
        for (int k = 0; k < RATIO; k++) begin
            tick();
            check_eq("sw_ack",  bus.o_wb4_out_sack,  1);
            check_eq("sw_data", bus.o_wb4_out_sdata, lane_of(32'h44332211, k));
        end
        check_eq("sw_stall_end", bus.o_wb4_out_sstall, 1);
        check_eq("sw_in_stgd",   bus.o_wb4_in_stgd,    1);
        drive_rd(1'b0);
        tick();
        check_eq("sw_no_ack", bus.o_wb4_out_sack, 0);

        // Fill: one word in hold plus DEPTH in memory, the next write refused
        wq.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic [W_I-1:0] w;
            w = $urandom;
            if (i < DEPTH + 1) wq.push_back(w);
            drive_wr(1'b1, w);
            tick();
            check_eq("fill_ack", bus.o_wb4_in_sack, (i < DEPTH + 1));
            if (i == DEPTH) begin
                check_eq("fill_sstall", bus.o_wb4_in_sstall, 1);
                check_eq("fill_stgd",   bus.o_wb4_out_stgd,  1);
            end
        end
        drive_wr(1'b0, '0);
        drive_rd(1'b1);
        read_expect("fill_drain", wq, (DEPTH + 1) * RATIO);
        check_eq("fill_empty", bus.o_wb4_in_stgd, 1);
        drive_rd(1'b0);
        tick();

        // Back-to-back words read without a bubble
        drive_rd(1'b1);
        drive_wr(1'b1, 32'hA3A2A1A0);
        tick();
        drive_wr(1'b1, 32'hB3B2B1B0);
        tick();
        drive_wr(1'b0, '0);
        begin
            int n = 0;
            while (!bus.o_wb4_out_sack && n < 20) begin tick(); n++; end
        end
        check_eq("b2b_start", bus.o_wb4_out_sack, 1);
        for (int i = 0; i < 2 * RATIO; i++) begin
            if (i > 0) tick();
            check_eq("b2b_ack",  bus.o_wb4_out_sack, 1);
            check_eq("b2b_data", bus.o_wb4_out_sdata,
                     lane_of((i < RATIO) ? 32'hA3A2A1A0 : 32'hB3B2B1B0, i % RATIO));
        end
        drive_rd(1'b0);
        tick();

        // Wrap-around with concurrent reads, then fully random traffic
        stream(12, 1'b1);
        stream(48, 1'b0);
        drive_rd(1'b1);
        begin
            int n = 0;
            while (!bus.o_wb4_in_stgd && n < 400) begin tick(); n++; end
        end
        check_eq("stream_drained", bus.o_wb4_in_stgd, 1);
        drive_rd(1'b0);
        tick();

        // Reset in the middle of a partially read word
        drive_wr(1'b1, 32'h0D0C0B0A);
        tick();
        drive_wr(1'b0, '0);
        drive_rd(1'b1);
        begin
            int got = 0;
            int n = 0;
            while (got < 2 && n < 20) begin
                tick(); n++;
                if (bus.o_wb4_out_sack) got++;
            end
            check_eq("mid_two_lanes", got, 2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_sstall", bus.o_wb4_out_sstall, 1);
        check_eq("mid_rst_ack",    bus.o_wb4_out_sack,   0);
        check_eq("mid_rst_stgd",   bus.o_wb4_in_stgd,    1);
        wq.delete();
        wq.push_back(32'h2D2C2B2A);
        drive_wr(1'b1, 32'h2D2C2B2A);
        tick();
        drive_wr(1'b0, '0);
        read_expect("mid_new", wq, RATIO);
        drive_rd(1'b0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        check_eq("watchdog", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
